// File: rtl/debounced_updown_selector.sv
// debounced_updown_selector
// Debounces two active-low push-buttons (up/down) and steps a modulo-MOD
// index once per clean press, with optional wrap or saturate at the ends.
// Each key runs through a 2-flop synchroniser, a SHIFT_DEPTH-sample window
// and a hysteresis state register; the count register reacts to the
// released->pressed transition of that state.
// Optional build macro: AUTO_REPEAT_EN adds per-key hold counters that
// generate repeat events while a key stays pressed.

module debounced_updown_selector #(
   parameter int SHIFT_DEPTH   = 16,
   parameter int MOD           = 3,
   parameter int CNT_W         = 2,
   parameter int RESET_VAL     = 0,
   parameter int WRAP_EN       = 1,
   parameter int HOLD_CYCLES   = 1000000,
   parameter int REPEAT_CYCLES = 250000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             key_up,
   input  logic             key_down,
   output logic [CNT_W-1:0] count_out,
   output logic             step_pulse,
   output logic             wrap_pulse
);

   localparam logic [CNT_W-1:0] MAX_VAL   = CNT_W'(MOD - 1);
   localparam logic [CNT_W-1:0] ZERO_VAL  = '0;
   localparam logic [CNT_W-1:0] ONE_VAL   = CNT_W'(1);
   localparam logic [CNT_W-1:0] RESET_CNT = CNT_W'(RESET_VAL);

   // Configurations outside the supported range land in an empty block
   localparam bit PARAMS_OK = (SHIFT_DEPTH >= 2) && (MOD >= 2) &&
                              ((64'd1 << CNT_W) >= 64'(MOD)) &&
                              (RESET_VAL < MOD) && (RESET_VAL >= 0) &&
                              (HOLD_CYCLES >= 1) && (REPEAT_CYCLES >= 1);
   if (!PARAMS_OK) begin : g_unsupportedParams
   end

   logic [1:0] w_keyRaw;
   logic [1:0] w_event;
   logic       w_up;
   logic       w_down;

   assign w_keyRaw = {key_down, key_up};

   for (genvar k = 0; k < 2; k++) begin : g_key
      logic                   r_sync1;
      logic                   r_sync2;
      logic [SHIFT_DEPTH-1:0] r_shift;
      logic                   r_pressed;
      logic                   r_pressedPrev;
      logic                   w_pressEvt;

      // Synchronise the raw key, keep a window of samples and move the
      // stable state only when the whole window agrees (hysteresis)
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_sync1       <= 1'b1;
            r_sync2       <= 1'b1;
            r_shift       <= '1;
            r_pressed     <= 1'b0;
            r_pressedPrev <= 1'b0;
         end else begin
            r_sync1       <= w_keyRaw[k];
            r_sync2       <= r_sync1;
            r_shift       <= {r_shift[SHIFT_DEPTH-2:0], r_sync2};
            if (r_shift == '0) begin
               r_pressed <= 1'b1;
            end else if (r_shift == '1) begin
               r_pressed <= 1'b0;
            end
            r_pressedPrev <= r_pressed;
         end
      end

      assign w_pressEvt = r_pressed & ~r_pressedPrev;

`ifdef AUTO_REPEAT_EN
      localparam int HOLD_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
      localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

      logic [HOLD_W-1:0] r_hold;
      logic              r_repeating;
      logic              w_repeatEvt;

      assign w_repeatEvt = r_pressed &&
                           (r_repeating ? (r_hold == HOLD_W'(REPEAT_CYCLES))
                                        : (r_hold == HOLD_W'(HOLD_CYCLES)));

      // Count cycles since the last press or repeat event while held;
      // the first gap is HOLD_CYCLES, later gaps are REPEAT_CYCLES
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_hold      <= '0;
            r_repeating <= 1'b0;
         end else if (!r_pressed) begin
            r_hold      <= '0;
            r_repeating <= 1'b0;
         end else if (w_pressEvt || w_repeatEvt) begin
            r_hold      <= HOLD_W'(1);
            r_repeating <= w_repeatEvt;
         end else begin
            r_hold      <= r_hold + HOLD_W'(1);
         end
      end

      assign w_event[k] = w_pressEvt | w_repeatEvt;
`else
      assign w_event[k] = w_pressEvt;
`endif
   end

   assign w_up   = w_event[0];
   assign w_down = w_event[1];

   logic [CNT_W-1:0] r_count;
   logic             r_step;
   logic             r_wrap;

   // Step the index on a lone up or down event; simultaneous events cancel
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= RESET_CNT;
         r_step  <= 1'b0;
         r_wrap  <= 1'b0;
      end else begin
         r_step <= 1'b0;
         r_wrap <= 1'b0;
         if (w_up && !w_down) begin
            if (r_count == MAX_VAL) begin
               if (WRAP_EN != 0) begin
                  r_count <= ZERO_VAL;
                  r_step  <= 1'b1;
                  r_wrap  <= 1'b1;
               end
            end else begin
               r_count <= r_count + ONE_VAL;
               r_step  <= 1'b1;
            end
         end else if (w_down && !w_up) begin
            if (r_count == ZERO_VAL) begin
               if (WRAP_EN != 0) begin
                  r_count <= MAX_VAL;
                  r_step  <= 1'b1;
                  r_wrap  <= 1'b1;
               end
            end else begin
               r_count <= r_count - ONE_VAL;
               r_step  <= 1'b1;
            end
         end
      end
   end

   assign count_out  = r_count;
   assign step_pulse = r_step;
   assign wrap_pulse = r_wrap;

endmodule

// File: doc/debounced_updown_selector.md
Name: debounced_updown_selector

Overview:
Parametrised two-key selector: debounces active-low "up" and "down" push-buttons and steps a modulo-MOD index up or down once per clean press. Generalises the single-key fixed 0..2 counter to any modulus, adds a down key, a wrap-or-saturate mode, a press-release hysteresis debounce and a step strobe. Sits between board keys and the song/mode select logic of the music player.

Parameters:
SHIFT_DEPTH, 16, debounce window in clk cycles (>=2)
MOD, 3, number of index values; count_out ranges 0..MOD-1 (>=2)
CNT_W, 2, width of count_out; must satisfy 2**CNT_W >= MOD
RESET_VAL, 0, count_out value after reset (< MOD)
WRAP_EN, 1, 1 = wrap at ends; 0 = saturate at 0 and MOD-1
HOLD_CYCLES, 1000000, auto-repeat initial hold delay (used only with AUTO_REPEAT_EN)
REPEAT_CYCLES, 250000, auto-repeat period (used only with AUTO_REPEAT_EN)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
key_up  input  1  raw up button, active low, idle high, asynchronous
key_down  input  1  raw down button, active low, idle high, asynchronous
count_out  output  CNT_W  current index
step_pulse  output  1  one-cycle strobe, high in the cycle count_out takes a new value
wrap_pulse  output  1  one-cycle strobe, high with step_pulse when the step wrapped (MOD-1->0 or 0->MOD-1)

Behaviour:
- Single clock clk; reset asynchronous, active-low (rst_n); all registers clear on rst_n low regardless of clk.
- Reset values: sync flops and shift registers all 1; stable states = released; count_out = RESET_VAL; step_pulse = 0; wrap_pulse = 0.
- Per key: 2-flop synchroniser -> SHIFT_DEPTH shift register -> stable state reg.
- Stable state goes pressed only when shift reg all 0; goes released only when all 1; otherwise holds (hysteresis).
- Press event = stable state released->pressed transition; one per press, none on release.
- Latency: key low from edge 1 onward -> stable pressed at edge SHIFT_DEPTH+3 -> count_out/step_pulse update at edge SHIFT_DEPTH+4.
- Any high sample inside the window restarts qualification; bounce shorter than SHIFT_DEPTH cycles never steps.
- Up event: count_out+1; at MOD-1 -> 0 with wrap_pulse (WRAP_EN=1) or hold, no step_pulse (WRAP_EN=0).
- Down event: count_out-1; at 0 -> MOD-1 with wrap_pulse (WRAP_EN=1) or hold, no step_pulse (WRAP_EN=0).
- Up and down events in same cycle: cancel; count_out unchanged, no strobes.
- Holding one key pressed never blocks the other key's events.
- Arithmetic in CNT_W bits; count_out never leaves 0..MOD-1.
- step_pulse and wrap_pulse registered, high exactly one cycle per event.
- Reset mid-press: state returns to reset values; a key still held after release of rst_n must requalify (full latency) and then produces one event.

Optional Feature:
AUTO_REPEAT_EN: when defined, each key has a hold counter; while stable pressed, a repeat event fires after HOLD_CYCLES cycles following the press event, then every REPEAT_CYCLES cycles, each acting exactly like a press event (same wrap/saturate/cancel rules). Counter clears on stable release or reset. When undefined: no hold counters synthesised, one event per press, HOLD_CYCLES/REPEAT_CYCLES ignored.

Test Plan:
SHIFT_DEPTH=4, MOD=3: key_up low from edge 1 -> count_out 0->1 and step_pulse high at edge 8 only; no further change while held.
Three clean up presses from 0 with WRAP_EN=1 -> 1,2,0; wrap_pulse high only on 2->0.
WRAP_EN=0, count_out=0, down press -> count_out stays 0, step_pulse and wrap_pulse stay 0.
key_up bouncing low 3 cycles/high 1 cycle for 40 cycles, then high -> count_out unchanged, no strobes.
key_up and key_down qualified on same edge -> count_out unchanged, no strobes; release both, press down -> count_out 0->2 with wrap_pulse (WRAP_EN=1).
AUTO_REPEAT_EN, HOLD_CYCLES=20, REPEAT_CYCLES=5, MOD=8: hold up 40 cycles past press event -> steps at +0, +20, +25, +30, +35, +40; count_out 0->6.
